// File: rtl/segasys1_sndcmd_tx.sv
// segasys1_sndcmd_tx: queues main-CPU sound commands and replays each as one
// sndno/sndstart strobe paced on clk8M_en, with a post-command gap for the sound NMI handler.
module segasys1_sndcmd_tx #(
  parameter int DEPTH_LOG2  = 2,
  parameter int SETUP_TICKS = 2,
  parameter int HOLD_TICKS  = 4,
  parameter int GAP_TICKS   = 2048
) (
  input  logic                clk48M,
  input  logic                reset,
  input  logic                clk8M_en,
  input  logic                cmd_wr,
  input  logic [7:0]          cmd_di,
  input  logic                ovf_clr,
  output logic [7:0]          sndno,
  output logic                sndstart,
  output logic                busy,
  output logic                fifo_full,
  output logic [DEPTH_LOG2:0] fifo_level,
  output logic                overflow
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [15:0] SETUP_LD = 16'(SETUP_TICKS - 1);
  localparam logic [15:0] HOLD_LD = 16'(HOLD_TICKS - 1);
  localparam logic [15:0] GAP_LD = 16'(GAP_TICKS - 1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;
  state_t state_q;
  logic [7:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0] level_q, level_d;
  logic [15:0] cnt_q;
  logic [7:0] sndno_q;
  logic sndstart_q, overflow_q, overflow_d;
  logic full, pop, push, ovf_set;
  // A pop frees a slot in the same cycle, so a write into a full FIFO is accepted then.
  always_comb begin
    full = level_q == FULL;
    pop = clk8M_en && state_q == IDLE && level_q != '0;
    push = cmd_wr && (!full || pop);
    ovf_set = cmd_wr && full && !pop;
    level_d = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    overflow_d = ovf_set || (overflow_q && !ovf_clr);
  end
  always_ff @(posedge clk48M)
    if (push) mem_q[wr_ptr_q] <= cmd_di;
  always_ff @(posedge clk48M or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      cnt_q <= '0;
      sndno_q <= '0;
      sndstart_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(push);
      rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(pop);
      level_q <= level_d;
      overflow_q <= overflow_d;
      if (clk8M_en)
        case (state_q)
          IDLE:
            if (pop) begin
              sndno_q <= mem_q[rd_ptr_q];
              cnt_q <= SETUP_LD;
              state_q <= SETUP;
            end
          SETUP:
            if (cnt_q == '0) begin
              sndstart_q <= 1'b1;
              cnt_q <= HOLD_LD;
              state_q <= STROBE;
            end else cnt_q <= cnt_q - 16'd1;
          STROBE:
            if (cnt_q == '0) begin
              sndstart_q <= 1'b0;
              cnt_q <= GAP_LD;
              state_q <= GAP;
            end else cnt_q <= cnt_q - 16'd1;
          GAP:
            if (cnt_q == '0) state_q <= IDLE;
            else cnt_q <= cnt_q - 16'd1;
          default: state_q <= IDLE;
        endcase
    end
  assign sndno = sndno_q;
  assign sndstart = sndstart_q;
  assign busy = state_q != IDLE || level_q != '0;
  assign fifo_full = full;
  assign fifo_level = level_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_segasys1_sndcmd_tx.sv
// tb_segasys1_sndcmd_tx: scoreboard bench; a sound-side edge-detector model pops
// expected bytes on each sndstart rise and checks setup, hold and command period.
module tb_segasys1_sndcmd_tx;
  logic clk48M = 1'b0, reset = 1'b1, clk8M_en = 1'b0, cmd_wr = 1'b0, ovf_clr = 1'b0;
  logic [7:0] cmd_di = '0, sndno;
  logic sndstart, busy, fifo_full, overflow;
  logic [2:0] fifo_level;
  int n_chk = 0, n_pass = 0;
  logic [7:0] exp_q [$];
  logic fast = 1'b0, en_hold = 1'b0;
  int en_cnt = 0;
  int ticks = 0, rise_tick = 0, chg_tick = 0, latches = 0, snap = 0;
  logic rise_valid = 1'b0, idle_seen = 1'b0, prev_start = 1'b0;
  logic [7:0] prev_no = '0;

  segasys1_sndcmd_tx dut (
    .clk48M(clk48M), .reset(reset), .clk8M_en(clk8M_en), .cmd_wr(cmd_wr),
    .cmd_di(cmd_di), .ovf_clr(ovf_clr), .sndno(sndno), .sndstart(sndstart),
    .busy(busy), .fifo_full(fifo_full), .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk48M = ~clk48M;

  initial forever begin
    @(negedge clk48M);
    en_cnt = (en_cnt == 5) ? 0 : en_cnt + 1;
    clk8M_en = !en_hold && (fast || en_cnt == 0);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Sound-side model: samples the link once per clk8M_en tick.
  always @(posedge clk48M) begin
    if (clk8M_en && !reset) begin
      #1;
      ticks++;
      if (!busy) idle_seen = 1'b1;
      if (sndstart && prev_start) chk("sndno_held", sndno, prev_no);
      if (sndstart && !prev_start) begin
        latches++;
        chk("rise_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("sndno", sndno, exp_q.pop_front());
        chk("setup_ticks", (ticks - chg_tick) >= 2, 1);
        if (rise_valid && !idle_seen) chk("period", ticks - rise_tick, 2055);
        rise_tick = ticks;
        rise_valid = 1'b1;
        idle_seen = 1'b0;
      end
      if (!sndstart && prev_start) chk("hold_ticks", ticks - rise_tick, 4);
      if (sndno !== prev_no) chg_tick = ticks;
      prev_start = sndstart;
      prev_no = sndno;
    end
  end

  task automatic wr(input logic [7:0] d, input logic accept, input logic clr);
    @(negedge clk48M);
    cmd_wr = 1'b1;
    cmd_di = d;
    ovf_clr = clr;
    if (accept) exp_q.push_back(d);
    @(negedge clk48M);
    cmd_wr = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk48M);
    ovf_clr = 1'b1;
    @(negedge clk48M);
    ovf_clr = 1'b0;
  endtask

  task automatic tick_wait();
    do @(posedge clk48M); while (!clk8M_en);
    #1;
  endtask

  task automatic wait_lvl(input string tag, input logic v, input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk48M);
      #1;
      if (sndstart === v) return;
    end
    chk(tag, 0, 1);
  endtask

  task automatic wait_idle(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk48M);
      #1;
      if (!busy) return;
    end
    chk(tag, 0, 1);
  endtask

  initial begin
    int n;
    #1;
    chk("rst_sndno", sndno, 0);
    chk("rst_sndstart", sndstart, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    repeat (3) @(negedge clk48M);
    reset = 1'b0;
    // Single command at the real 4-per-24 cadence.
    wr(8'h81, 1'b1, 1'b0);
    chk("t1_level1", fifo_level, 1);
    tick_wait();
    chk("t1_level0", fifo_level, 0);
    chk("t1_sndno", sndno, 8'h81);
    chk("t1_low", sndstart, 0);
    wait_lvl("t1_to_rise", 1'b1, 200);
    wait_lvl("t1_to_fall", 1'b0, 200);
    n = 0;
    while (busy && n < 3000) begin
      tick_wait();
      n++;
    end
    chk("t1_gap", n, 2048);
    chk("t1_latch_once", latches, 1);
    chk("t1_sb_empty", exp_q.size(), 0);
    fast = 1'b1;
    repeat (4) @(negedge clk48M);
    // Burst of five; the first pops while the rest fill the FIFO.
    for (int i = 1; i <= 5; i++) wr(8'(i), 1'b1, 1'b0);
    chk("burst_level", fifo_level, 4);
    chk("burst_full", fifo_full, 1);
    chk("burst_ovf", overflow, 0);
    wr(8'hEE, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", fifo_level, 4);
    clr_pulse();
    chk("ovf_clr", overflow, 0);
    wr(8'h77, 1'b0, 1'b1);
    chk("ovf_set_wins", overflow, 1);
    clr_pulse();
    chk("ovf_clr2", overflow, 0);
    // Refill during 02's gap, then write exactly on 03's pop tick.
    wait_lvl("b_to_rise", 1'b1, 5000);
    wait_lvl("b_to_fall", 1'b0, 100);
    wr(8'h06, 1'b1, 1'b0);
    repeat (2046) @(negedge clk48M);
    chk("pre_pop_level", fifo_level, 4);
    chk("pre_pop_full", fifo_full, 1);
    wr(8'h07, 1'b1, 1'b0);
    chk("pop_wr_level", fifo_level, 4);
    chk("pop_wr_ovf", overflow, 0);
    wait_idle("burst_drain", 20000);
    chk("burst_sb_empty", exp_q.size(), 0);
    // Reset during STROBE with one entry still queued.
    wr(8'h55, 1'b1, 1'b0);
    wr(8'h66, 1'b0, 1'b0);
    wait_lvl("r_to_rise", 1'b1, 100);
    chk("r_level_pre", fifo_level, 1);
    @(negedge clk48M);
    #2;
    reset = 1'b1;
    #1;
    chk("r_sndstart", sndstart, 0);
    chk("r_level", fifo_level, 0);
    chk("r_busy", busy, 0);
    exp_q.delete();
    rise_valid = 1'b0;
    prev_start = 1'b0;
    @(negedge clk48M);
    reset = 1'b0;
    snap = latches;
    wr(8'h3C, 1'b1, 1'b0);
    wait_lvl("r3c_to_rise", 1'b1, 100);
    wait_lvl("r3c_to_fall", 1'b0, 100);
    // Freeze mid-gap; writes still land.
    repeat (100) @(negedge clk48M);
    en_hold = 1'b1;
    @(negedge clk48M);
    chk("frz_level0", fifo_level, 0);
    wr(8'hA1, 1'b1, 1'b0);
    chk("frz_level1", fifo_level, 1);
    repeat (40) @(negedge clk48M);
    wr(8'hA2, 1'b1, 1'b0);
    chk("frz_level2", fifo_level, 2);
    repeat (54) @(negedge clk48M);
    chk("frz_sndstart", sndstart, 0);
    chk("frz_busy", busy, 1);
    chk("frz_sndno", sndno, 8'h3C);
    en_hold = 1'b0;
    wait_idle("frz_drain", 10000);
    chk("frz_latches", latches - snap, 3);
    chk("frz_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
